antisat_key_loader: RTL

- Sequential key-delivery block that feeds the keyinput bus of an Anti-SAT-locked combinational netlist, such as the 32-key c432 variants.
- Receives the activation key as a byte stream over a valid/ready interface and checks an XOR checksum.
- Commits the key to an output register only after the frame validates; until then the key bus is held at all-zero, so the circuit stays locked.
- Sits between the provisioning/test interface and the obfuscated core.

---
 rtl/antisat_pkg.sv | 29 ++
 rtl/antisat_key_loader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/antisat_pkg.sv
// Shared types, constants and the reference checksum fold for the
// Anti-SAT key loader.
package antisat_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DRAIN = 2'd3
    } loader_state_e;

    localparam int BYTE_W    = 8;
    // Widest key the fold helper accepts; callers zero-extend narrower keys.
    localparam int MAX_KEY_W = 256;

    // XOR of the low nbytes bytes of key: the checksum a valid frame carries.
    function automatic logic [BYTE_W-1:0] key_xor_fold(input logic [MAX_KEY_W-1:0] key,
                                                       input int nbytes);
        logic [BYTE_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < MAX_KEY_W / BYTE_W; i++) begin
            if (i < nbytes) begin
                acc = acc ^ key[i*BYTE_W +: BYTE_W];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/antisat_key_loader.sv
// Anti-SAT key loader: receives key bytes LSB first plus an XOR checksum
// over a valid/ready byte stream and commits the key to key_out only when
// the whole frame validates. Until then key_out stays all-zero.
//
// Handshake: a byte moves on a rising edge where s_valid && s_ready. The
// source may raise s_valid at any time and must hold s_data/s_last until
// the transfer edge. s_ready is low only during reset and in CHECK.
module antisat_key_loader
    import antisat_pkg::*;
#(
    parameter int KEY_W = 32   // multiple of 8, at least 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             err,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int NBYTES = KEY_W / BYTE_W;
    localparam int CW     = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES);

    loader_state_e     r_state;
    loader_state_e     w_state_nx;
    logic [CW-1:0]     r_count;
    logic [KEY_W-1:0]  r_shadow;
    logic [BYTE_W-1:0] r_csum;
    logic [KEY_W-1:0]  r_key;
    logic              r_key_valid;
    logic              r_err;
    logic              r_match;     // checksum byte equalled running XOR
    logic              r_ck_last;   // s_last seen on the checksum byte
    logic              w_xfer;
    logic              w_commit;
    logic              w_fail;

    assign s_ready   = !rst && (r_state != CHECK);
    assign w_xfer    = s_valid && s_ready;
    assign key_out   = r_key;
    assign key_valid = r_key_valid;
    assign err       = r_err;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

    // State register; rst beats clear, clear beats everything else.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state plus commit/reject decisions for the current cycle.
    always_comb begin
        w_state_nx = r_state;
        w_commit   = 1'b0;
        w_fail     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    if (s_last) begin
                        w_fail = 1'b1;          // one-byte frame: reject, stay idle
                    end else begin
                        w_state_nx = LOAD;
                    end
                end
            end
            LOAD: begin
                if (w_xfer) begin
                    if (r_count == LAST_CNT) begin
                        w_state_nx = CHECK;     // this byte is the checksum
                    end else if (s_last) begin
                        w_fail     = 1'b1;      // short frame
                        w_state_nx = IDLE;
                    end
                end
            end
            CHECK: begin
                if (r_match && r_ck_last) begin
                    w_commit = 1'b1;
                end else begin
                    w_fail = 1'b1;
                end
                // Without s_last on the checksum the frame tail must be drained.
                w_state_nx = r_ck_last ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (w_xfer && s_last) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Shadow/checksum accumulation and the committed key register.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count     <= '0;
            r_shadow    <= '0;
            r_csum      <= '0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_err       <= 1'b0;
            r_match     <= 1'b0;
            r_ck_last   <= 1'b0;
        end else begin
            r_err <= w_fail;
            if (w_fail) begin
                // A rejected frame also revokes any previously committed key.
                r_key       <= '0;
                r_key_valid <= 1'b0;
                r_shadow    <= '0;
                r_count     <= '0;
                r_csum      <= '0;
            end else if (w_commit) begin
                r_key       <= r_shadow;
                r_key_valid <= 1'b1;
                r_shadow    <= '0;
                r_count     <= '0;
                r_csum      <= '0;
            end else if (w_xfer && (r_state == IDLE)) begin
                r_shadow[BYTE_W-1:0] <= s_data;
                r_count              <= CW'(1);
                r_csum               <= s_data;
            end else if (w_xfer && (r_state == LOAD)) begin
                if (r_count == LAST_CNT) begin
                    r_match   <= (s_data == r_csum);
                    r_ck_last <= s_last;
                end else begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (r_count == CW'(k)) begin
                            r_shadow[k*BYTE_W +: BYTE_W] <= s_data;
                        end
                    end
                    r_count <= r_count + CW'(1);
                    r_csum  <= r_csum ^ s_data;
                end
            end
        end
    end

endmodule
